// File: rtl/instruction_cache_refill_controller_pkg.sv
// Shared definitions for the instruction cache refill controller: state encoding,
// default geometry and the address-split widths derived from it.
package instruction_cache_refill_controller_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam int unsigned DEFAULT_LINE_WORDS = 4;
    localparam int unsigned DEFAULT_SETS       = 64;
    localparam int unsigned DEFAULT_WORD_W     = $clog2(DEFAULT_LINE_WORDS);
    localparam int unsigned DEFAULT_OFFSET_W   = DEFAULT_WORD_W + 2;
    localparam int unsigned DEFAULT_INDEX_W    = $clog2(DEFAULT_SETS);
    localparam int unsigned DEFAULT_TAG_W      = ADDR_W - DEFAULT_INDEX_W - DEFAULT_OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INVAL = 3'd1,
        ST_REQ   = 3'd2,
        ST_FILL  = 3'd3,
        ST_TAG   = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    // Counter width able to hold both a word offset and a set index.
    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/instruction_cache_refill_controller_word_counter.sv
// Generic up-counter with synchronous clear, enable and a programmable terminal flag.
module refill_word_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             terminal_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal_c = (count == last);

endmodule

// File: rtl/instruction_cache_refill_controller.sv
// Instruction cache miss handler: invalidates the victim line, reads the line from
// memory, writes the data/tag arrays, and serialises fence.i flushes behind refills.
module instruction_cache_refill_controller
    import instruction_cache_refill_controller_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int unsigned SETS       = DEFAULT_SETS,
    parameter logic        HIGH       = 1'b1,
    parameter logic        LOW        = 1'b0
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               miss,
    input  logic [ADDR_W-1:0]                                  miss_addr,
    input  logic                                               flush,
    output logic                                               instruction_cache_stall,
    output logic                                               mem_req,
    output logic [ADDR_W-1:0]                                  mem_addr,
    input  logic                                               mem_ack,
    input  logic                                               mem_rdata_valid,
    input  logic [DATA_W-1:0]                                  mem_rdata,
    output logic                                               fill_write,
    output logic [$clog2(SETS)-1:0]                            fill_index,
    output logic [$clog2(LINE_WORDS)-1:0]                      fill_word,
    output logic [DATA_W-1:0]                                  fill_data,
    output logic                                               tag_write,
    output logic [$clog2(SETS)-1:0]                            tag_index,
    output logic [ADDR_W-$clog2(SETS)-$clog2(LINE_WORDS)-3:0]  tag_value,
    output logic                                               tag_valid,
    output logic [31:0]                                        miss_count
);

    localparam int unsigned WORD_W   = $clog2(LINE_WORDS);
    localparam int unsigned OFFSET_W = WORD_W + 2;
    localparam int unsigned INDEX_W  = $clog2(SETS);
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned CNT_W    = max_w(WORD_W, INDEX_W);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

    state_t            state;
    logic              pending;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_last;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_terminal_c;
    logic              beat_c;

    // One counter walks words during FILL and set indices during FLUSH.
    assign beat_c     = (state == ST_FILL) && mem_rdata_valid;
    assign cnt_clear  = (state != ST_FILL) && (state != ST_FLUSH);
    assign cnt_enable = beat_c || (state == ST_FLUSH);
    assign count_last = (state == ST_FLUSH) ? CNT_W'(SETS - 1) : CNT_W'(LINE_WORDS - 1);

    refill_word_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .last       (count_last),
        .count      (count),
        .terminal_c (cnt_terminal_c)
    );

    // Reset leaves a flush pending so every tag is invalidated before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= HIGH;
            base       <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending || flush) begin
                        state <= ST_FLUSH;
                    end else if (miss) begin
                        state      <= ST_INVAL;
                        base       <= miss_addr & ~LINE_MASK;
                        miss_count <= miss_count + 32'd1;
                    end
                end
                ST_INVAL: state <= ST_REQ;
                ST_REQ: begin
                    if (mem_ack) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat_c && cnt_terminal_c) begin
                        state <= ST_TAG;
                    end
                end
                ST_TAG: state <= ST_IDLE;
                ST_FLUSH: begin
                    if (cnt_terminal_c) begin
                        state   <= ST_IDLE;
                        pending <= LOW;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A flush seen mid-refill waits; one seen while flushing is absorbed.
            if (flush && (state inside {ST_INVAL, ST_REQ, ST_FILL, ST_TAG})) begin
                pending <= HIGH;
            end
        end
    end

    assign instruction_cache_stall = (state != ST_IDLE) || miss || flush || pending;

    assign mem_req  = (state == ST_REQ) ? HIGH : LOW;
    assign mem_addr = base;

    assign fill_write = beat_c ? HIGH : LOW;
    assign fill_index = base[OFFSET_W +: INDEX_W];
    assign fill_word  = count[WORD_W-1:0];
    assign fill_data  = mem_rdata;

    assign tag_write = (state inside {ST_INVAL, ST_TAG, ST_FLUSH}) ? HIGH : LOW;
    assign tag_valid = (state == ST_TAG) ? HIGH : LOW;
    assign tag_index = (state == ST_FLUSH) ? count[INDEX_W-1:0] : base[OFFSET_W +: INDEX_W];
    assign tag_value = base[ADDR_W-1 -: TAG_W];

endmodule

// File: tb/tb_instruction_cache_refill_controller.sv
// Bench for the refill controller: directed and randomized refills and flushes,
// with tag/data array writes collected and compared against an address-arithmetic model.
module tb_instruction_cache_refill_controller;

    localparam int unsigned LW   = 4;
    localparam int unsigned SETS = 64;
    localparam int unsigned WW   = 2;
    localparam int unsigned IW   = 6;
    localparam int unsigned TW   = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss = 1'b0;
    logic [31:0]   miss_addr = '0;
    logic          flush = 1'b0;
    logic          stall;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack = 1'b0;
    logic          mem_rdata_valid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          fill_write;
    logic [IW-1:0] fill_index;
    logic [WW-1:0] fill_word;
    logic [31:0]   fill_data;
    logic          tag_write;
    logic [IW-1:0] tag_index;
    logic [TW-1:0] tag_value;
    logic          tag_valid;
    logic [31:0]   miss_count;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [TW-1:0] tag;
        logic          valid;
    } tag_wr_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [WW-1:0] word;
        logic [31:0]   data;
    } fill_wr_t;

    tag_wr_t  tag_q[$];
    fill_wr_t fill_q[$];
    int       n_pass = 0;
    int       n_fail = 0;
    int       n_total = 0;
    logic [31:0] exp_count = '0;

    instruction_cache_refill_controller #(
        .LINE_WORDS (LW),
        .SETS       (SETS)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .miss                    (miss),
        .miss_addr               (miss_addr),
        .flush                   (flush),
        .instruction_cache_stall (stall),
        .mem_req                 (mem_req),
        .mem_addr                (mem_addr),
        .mem_ack                 (mem_ack),
        .mem_rdata_valid         (mem_rdata_valid),
        .mem_rdata               (mem_rdata),
        .fill_write              (fill_write),
        .fill_index              (fill_index),
        .fill_word               (fill_word),
        .fill_data               (fill_data),
        .tag_write               (tag_write),
        .tag_index               (tag_index),
        .tag_value               (tag_value),
        .tag_valid               (tag_valid),
        .miss_count              (miss_count)
    );

    always #5 clk = ~clk;

    // Array-write monitor, sampled late in the low phase after inputs settle.
    always @(negedge clk) begin
        #3;
        if (tag_write === 1'b1) tag_q.push_back({tag_index, tag_value, tag_valid});
        if (fill_write === 1'b1) fill_q.push_back({fill_index, fill_word, fill_data});
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int limit, output int cycles);
        cycles = 0;
        while (stall === 1'b1 && cycles < limit) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk(name, 64'(stall), 64'(0));
    endtask

    task automatic check_flush(input string name, input int start);
        int bad = 0;
        for (int k = 0; k < int'(SETS); k++) begin
            if (tag_q[start + k].idx !== IW'(k) || tag_q[start + k].valid !== 1'b0) bad++;
        end
        chk(name, 64'(bad), 64'(0));
    endtask

    task automatic refill(input logic [31:0] addr, input int ack_dly, input int gap,
                          input int flush_beat);
        logic [31:0]   base;
        logic [IW-1:0] idx;
        logic [TW-1:0] tg;
        logic [31:0]   data [LW];
        int            cycles;
        int            bad;
        int            exp_tags;
        base = (addr / (LW * 4)) * (LW * 4);
        idx  = IW'((addr / (LW * 4)) % SETS);
        tg   = TW'(addr / (LW * 4 * SETS));
        tag_q.delete();
        fill_q.delete();
        repeat (2) begin
            @(negedge clk);
            mem_rdata_valid = 1'b1;
            mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        miss = 1'b1;
        miss_addr = addr;
        #1 chk("stall_on_miss", 64'(stall), 64'(1));
        @(negedge clk);
        miss = 1'b0;
        miss_addr = $urandom;
        exp_count++;
        #1 chk("miss_count_start", 64'(miss_count), 64'(exp_count));
        cycles = 0;
        while (mem_req !== 1'b1 && cycles < 8) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("mem_req", 64'(mem_req), 64'(1));
        chk("mem_addr", 64'(mem_addr), 64'(base));
        repeat (ack_dly) begin
            miss = 1'($urandom);
            miss_addr = $urandom;
            mem_rdata_valid = 1'($urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            #1;
            chk("mem_req_hold", 64'(mem_req), 64'(1));
            chk("mem_addr_hold", 64'(mem_addr), 64'(base));
        end
        miss = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < int'(LW); i++) begin
            data[i] = $urandom;
            mem_rdata_valid = 1'b1;
            mem_rdata = data[i];
            if (i == flush_beat) flush = 1'b1;
            #1;
            chk("fill_write", 64'(fill_write), 64'(1));
            chk("fill_word", 64'(fill_word), 64'(i));
            @(negedge clk);
            mem_rdata_valid = 1'b0;
            flush = 1'b0;
            mem_rdata = $urandom;
            repeat (gap) @(negedge clk);
        end
        wait_idle("refill_done", 300, cycles);
        exp_tags = (flush_beat >= 0) ? 2 + int'(SETS) : 2;
        chk("tag_writes", 64'(tag_q.size()), 64'(exp_tags));
        chk("fill_writes", 64'(fill_q.size()), 64'(LW));
        if (tag_q.size() == exp_tags) begin
            chk("inval", 64'({tag_q[0].idx, tag_q[0].valid}), 64'({idx, 1'b0}));
            chk("tag_fill", 64'(tag_q[1]), 64'({idx, tg, 1'b1}));
            if (flush_beat >= 0) check_flush("flush_after_refill", 2);
        end
        if (fill_q.size() == LW) begin
            bad = 0;
            for (int i = 0; i < int'(LW); i++) begin
                if (fill_q[i] !== {idx, WW'(i), data[i]}) bad++;
            end
            chk("fill_data", 64'(bad), 64'(0));
        end
        chk("miss_count_end", 64'(miss_count), 64'(exp_count));
    endtask

    initial begin
        int          cycles;
        int          bad;
        logic [31:0] a;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 64'(stall), 64'(1));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_tag_write", 64'(tag_write), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_miss_count", 64'(miss_count), 64'(0));
        tag_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("reset_flush_end", 200, cycles);
        chk("reset_flush_cycles", 64'(cycles), 64'(SETS + 1));
        chk("reset_flush_writes", 64'(tag_q.size()), 64'(SETS));
        if (tag_q.size() == SETS) check_flush("reset_flush_order", 0);

        refill(32'h0000_1234, 3, 1, -1);
        refill($urandom, 2, 1, 1);
        for (int t = 0; t < 6; t++) begin
            refill($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                   (t == 3) ? 0 : -1);
        end

        // Second flush pulse lands mid-flush and must be absorbed.
        tag_q.delete();
        @(negedge clk);
        flush = 1'b1;
        #1 chk("stall_on_flush", 64'(stall), 64'(1));
        @(negedge clk);
        flush = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle("flush_merge_end", 200, cycles);
        chk("flush_merge_writes", 64'(tag_q.size()), 64'(SETS));
        if (tag_q.size() == SETS) check_flush("flush_merge_order", 0);

        // Reset in the middle of a fill.
        a = $urandom;
        tag_q.delete();
        fill_q.delete();
        @(negedge clk);
        miss = 1'b1;
        miss_addr = a;
        @(negedge clk);
        miss = 1'b0;
        cycles = 0;
        while (mem_req !== 1'b1 && cycles < 8) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("abort_mem_req", 64'(mem_req), 64'(1));
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = $urandom;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_fill_write", 64'(fill_write), 64'(0));
        chk("abort_mem_req_low", 64'(mem_req), 64'(0));
        chk("abort_tag_write", 64'(tag_write), 64'(0));
        chk("abort_miss_count", 64'(miss_count), 64'(0));
        mem_rdata_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        wait_idle("abort_flush_end", 200, cycles);
        chk("abort_flush_cycles", 64'(cycles), 64'(SETS + 1));
        chk("abort_fill_writes", 64'(fill_q.size()), 64'(2));
        bad = 0;
        foreach (tag_q[k]) if (tag_q[k].valid !== 1'b0) bad++;
        chk("abort_no_valid_tag", 64'(bad), 64'(0));
        chk("abort_tag_writes", 64'(tag_q.size()), 64'(SETS + 1));
        if (tag_q.size() == SETS + 1) check_flush("abort_flush_order", 1);
        chk("abort_count_after", 64'(miss_count), 64'(0));

        refill($urandom, 1, 0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
